regfile_scoreboard: RTL and testbench

- Parametrised register file with two registered read ports and one write port.
- Fetch and writeback can happen in the same cycle, with write-to-read bypass.
- Optional hardwired-zero register 0.
- A per-register pending (scoreboard) bit tracks outstanding writes. The decode/issue stage uses it to detect RAW and WAW hazards between fetch and writeback.

---
 rtl/regfile_scoreboard.sv | 191 +++++++++++++++++++
 tb/tb_regfile_scoreboard.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//
// Register file with two registered read ports, one write port and a
// per-register pending (scoreboard) bit. The issue stage uses the pending
// bits to detect read-after-write hazards on fetched operands and
// write-after-write hazards on the destination it is about to reserve.
//
// Parameters:
//   DataSize - width of each register
//   AddrSize - address width; the file holds 2**AddrSize registers
//   ZeroReg  - 1: register 0 always reads 0 and ignores writes and reservations
//
// Ports:
//   clock, reset          - rising-edge clock, asynchronous active-high reset
//   enable_fetch          - capture both read operands on this edge
//   read_address1/2       - operand addresses
//   read_data1/2          - registered operand values (with writeback bypass)
//   read_valid            - registered; operands captured by the last edge
//                           had no outstanding producer
//   enable_writeback      - write write_data to write_address, clear its pending bit
//   write_address/data    - writeback destination and value
//   reserve_enable        - mark reserve_address as pending
//   reserve_address       - destination being reserved
//   reserve_conflict      - combinational; reserve_address is pending right now
//   pending_count         - registered number of pending registers

module regfile_scoreboard #(
    parameter int DataSize = 32,
    parameter int AddrSize = 5,
    parameter bit ZeroReg  = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable_fetch,
    input  logic [AddrSize-1:0] read_address1,
    input  logic [AddrSize-1:0] read_address2,
    output logic [DataSize-1:0] read_data1,
    output logic [DataSize-1:0] read_data2,
    output logic                read_valid,
    input  logic                enable_writeback,
    input  logic [AddrSize-1:0] write_address,
    input  logic [DataSize-1:0] write_data,
    input  logic                reserve_enable,
    input  logic [AddrSize-1:0] reserve_address,
    output logic                reserve_conflict,
    output logic [AddrSize:0]   pending_count
);

    localparam int Depth = 2 ** AddrSize;

    logic [DataSize-1:0] mem_q [Depth];
    logic [DataSize-1:0] mem_d [Depth];
    logic [Depth-1:0]    pending_q;
    logic [Depth-1:0]    pending_d;
    logic [DataSize-1:0] read_data1_q;
    logic [DataSize-1:0] read_data1_d;
    logic [DataSize-1:0] read_data2_q;
    logic [DataSize-1:0] read_data2_d;
    logic                read_valid_q;
    logic                read_valid_d;
    logic [AddrSize:0]   pending_count_q;
    logic [AddrSize:0]   pending_count_d;

    logic                wb_active;
    logic                rsv_active;
    logic                rd1_is_zero;
    logic                rd2_is_zero;
    logic                rsv_is_zero;
    logic                wb_hits_rd1;
    logic                wb_hits_rd2;
    logic [DataSize-1:0] op1_value;
    logic [DataSize-1:0] op2_value;
    logic                op1_pending;
    logic                op2_pending;
    logic                count_inc;
    logic                count_dec;

    // Qualify each operation. With a hardwired zero register, writes and
    // reservations aimed at register 0 simply never happen, so no later
    // logic has to special-case them.
    always_comb begin
        rd1_is_zero = ZeroReg && (read_address1 == '0);
        rd2_is_zero = ZeroReg && (read_address2 == '0);
        rsv_is_zero = ZeroReg && (reserve_address == '0);
        wb_active   = enable_writeback && !(ZeroReg && (write_address == '0));
        rsv_active  = reserve_enable && !rsv_is_zero;
        wb_hits_rd1 = wb_active && (write_address == read_address1);
        wb_hits_rd2 = wb_active && (write_address == read_address2);
    end

    // Operand values and hazard status as seen by a fetch on this edge.
    // A writeback landing in the same cycle both forwards its data and
    // retires the producer, so that operand is no longer pending. A
    // same-cycle reservation belongs to a younger instruction and is not
    // considered here.
    always_comb begin
        op1_value   = mem_q[read_address1];
        op2_value   = mem_q[read_address2];
        if (wb_hits_rd1) begin
            op1_value = write_data;
        end
        if (wb_hits_rd2) begin
            op2_value = write_data;
        end
        if (rd1_is_zero) begin
            op1_value = '0;
        end
        if (rd2_is_zero) begin
            op2_value = '0;
        end
        op1_pending = pending_q[read_address1] && !wb_hits_rd1 && !rd1_is_zero;
        op2_pending = pending_q[read_address2] && !wb_hits_rd2 && !rd2_is_zero;
    end

    // Read port registers: operands are held between fetches, while
    // read_valid only ever describes the fetch of the immediately
    // preceding edge.
    always_comb begin
        read_data1_d = read_data1_q;
        read_data2_d = read_data2_q;
        read_valid_d = 1'b0;
        if (enable_fetch) begin
            read_data1_d = op1_value;
            read_data2_d = op2_value;
            read_valid_d = !op1_pending && !op2_pending;
        end
    end

    // Storage and scoreboard update. The reservation is applied after the
    // writeback so that a same-address pair leaves the register pending:
    // the new producer is still outstanding even though data just landed.
    always_comb begin
        mem_d     = mem_q;
        pending_d = pending_q;
        if (wb_active) begin
            mem_d[write_address]     = write_data;
            pending_d[write_address] = 1'b0;
        end
        if (rsv_active) begin
            pending_d[reserve_address] = 1'b1;
        end
    end

    // Population count of the pending bits, maintained incrementally. A
    // reserve only adds when the bit was clear; a writeback only removes
    // when the bit was set and is not immediately re-set by a reserve of
    // the same address. Both may fire together on different addresses,
    // which nets to zero.
    always_comb begin
        count_inc       = rsv_active && !pending_q[reserve_address];
        count_dec       = wb_active && pending_q[write_address]
                          && !(rsv_active && (reserve_address == write_address));
        pending_count_d = pending_count_q
                          + {{AddrSize{1'b0}}, count_inc}
                          - {{AddrSize{1'b0}}, count_dec};
    end

    // All state clears immediately on reset; anything in flight in that
    // cycle is discarded.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            pending_q       <= '0;
            read_data1_q    <= '0;
            read_data2_q    <= '0;
            read_valid_q    <= 1'b0;
            pending_count_q <= '0;
        end else begin
            mem_q           <= mem_d;
            pending_q       <= pending_d;
            read_data1_q    <= read_data1_d;
            read_data2_q    <= read_data2_d;
            read_valid_q    <= read_valid_d;
            pending_count_q <= pending_count_d;
        end
    end

    // The WAW check looks at the registered state only; a writeback in the
    // same cycle does not hide a conflict from the issuer.
    always_comb begin
        reserve_conflict = pending_q[reserve_address] && !rsv_is_zero;
    end

    assign read_data1    = read_data1_q;
    assign read_data2    = read_data2_q;
    assign read_valid    = read_valid_q;
    assign pending_count = pending_count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard. Two instances share every input: one
// with a hardwired zero register and one where register 0 is ordinary.
// Directed vectors are checked against hand-derived constants; every cycle
// is also checked against a behavioural model of both instances.

module tb_regfile_scoreboard;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable_fetch;
    logic [AW-1:0] read_address1;
    logic [AW-1:0] read_address2;
    logic          enable_writeback;
    logic [AW-1:0] write_address;
    logic [DW-1:0] write_data;
    logic          reserve_enable;
    logic [AW-1:0] reserve_address;

    logic [DW-1:0] rd1Z, rd2Z, rd1N, rd2N;
    logic          validZ, validN, confZ, confN;
    logic [AW:0]   cntZ, cntN;

    int checks   = 0;
    int failures = 0;

    // Behavioural model, index 0 = ZeroReg=1 instance, 1 = ZeroReg=0 instance
    logic [DW-1:0] mMem  [2][DEPTH];
    bit            mPend [2][DEPTH];
    logic [DW-1:0] mRd1  [2];
    logic [DW-1:0] mRd2  [2];
    bit            mValid[2];
    int            mCnt  [2];

    typedef struct {
        logic          fetch;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic          wb;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          rs;
        logic [AW-1:0] rsa;
        logic          expConf;
        logic [DW-1:0] expRd1;
        logic [DW-1:0] expRd2;
        logic          expValid;
        logic [AW:0]   expCnt;
    } vec_t;

    vec_t vecs[11];

    regfile_scoreboard #(.DataSize(DW), .AddrSize(AW), .ZeroReg(1'b1)) dutZero (
        .clock(clock), .reset(reset),
        .enable_fetch(enable_fetch),
        .read_address1(read_address1), .read_address2(read_address2),
        .read_data1(rd1Z), .read_data2(rd2Z), .read_valid(validZ),
        .enable_writeback(enable_writeback),
        .write_address(write_address), .write_data(write_data),
        .reserve_enable(reserve_enable), .reserve_address(reserve_address),
        .reserve_conflict(confZ), .pending_count(cntZ)
    );

    regfile_scoreboard #(.DataSize(DW), .AddrSize(AW), .ZeroReg(1'b0)) dutPlain (
        .clock(clock), .reset(reset),
        .enable_fetch(enable_fetch),
        .read_address1(read_address1), .read_address2(read_address2),
        .read_data1(rd1N), .read_data2(rd2N), .read_valid(validN),
        .enable_writeback(enable_writeback),
        .write_address(write_address), .write_data(write_data),
        .reserve_enable(reserve_enable), .reserve_address(reserve_address),
        .reserve_conflict(confN), .pending_count(cntN)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic f, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                 input logic wb, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input logic rs, input logic [AW-1:0] rsa);
        enable_fetch     = f;
        read_address1    = a1;
        read_address2    = a2;
        enable_writeback = wb;
        write_address    = wa;
        write_data       = wd;
        reserve_enable   = rs;
        reserve_address  = rsa;
    endtask

    function automatic void modelReset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < DEPTH; i++) begin
                mMem[m][i]  = '0;
                mPend[m][i] = 1'b0;
            end
            mRd1[m]   = '0;
            mRd2[m]   = '0;
            mValid[m] = 1'b0;
            mCnt[m]   = 0;
        end
    endfunction

    function automatic bit isZeroReg(input int m, input int a);
        return (m == 0) && (a == 0);
    endfunction

    function automatic bit modelConflict(input int m, input int a);
        return isZeroReg(m, a) ? 1'b0 : mPend[m][a];
    endfunction

    // One clock edge of the architectural rules, applied to the current inputs
    function automatic void modelStep();
        int  a1, a2, wa, ra;
        bit  wbe, rse, p1, p2;
        a1 = int'(read_address1);
        a2 = int'(read_address2);
        wa = int'(write_address);
        ra = int'(reserve_address);
        for (int m = 0; m < 2; m++) begin
            wbe = enable_writeback && !isZeroReg(m, wa);
            rse = reserve_enable && !isZeroReg(m, ra);
            if (enable_fetch) begin
                mRd1[m] = isZeroReg(m, a1) ? '0 : ((wbe && wa == a1) ? write_data : mMem[m][a1]);
                mRd2[m] = isZeroReg(m, a2) ? '0 : ((wbe && wa == a2) ? write_data : mMem[m][a2]);
                p1 = !isZeroReg(m, a1) && mPend[m][a1] && !(wbe && wa == a1);
                p2 = !isZeroReg(m, a2) && mPend[m][a2] && !(wbe && wa == a2);
                mValid[m] = !p1 && !p2;
            end else begin
                mValid[m] = 1'b0;
            end
            if (wbe) begin
                mMem[m][wa]  = write_data;
                mPend[m][wa] = 1'b0;
            end
            if (rse) begin
                mPend[m][ra] = 1'b1;
            end
            mCnt[m] = 0;
            for (int i = 0; i < DEPTH; i++) begin
                mCnt[m] += int'(mPend[m][i]);
            end
        end
    endfunction

    // Inputs are already driven; check the combinational conflict, advance
    // the model, let the edge happen and compare registered outputs.
    task automatic applyCycle();
        #1;
        checkOutput("conflictZ", {31'b0, confZ}, {31'b0, modelConflict(0, int'(reserve_address))});
        checkOutput("conflictN", {31'b0, confN}, {31'b0, modelConflict(1, int'(reserve_address))});
        modelStep();
        @(posedge clock);
        @(negedge clock);
        checkOutput("rd1Z", rd1Z, mRd1[0]);
        checkOutput("rd2Z", rd2Z, mRd2[0]);
        checkOutput("validZ", {31'b0, validZ}, {31'b0, mValid[0]});
        checkOutput("cntZ", {26'b0, cntZ}, DW'(mCnt[0]));
        checkOutput("rd1N", rd1N, mRd1[1]);
        checkOutput("rd2N", rd2N, mRd2[1]);
        checkOutput("validN", {31'b0, validN}, {31'b0, mValid[1]});
        checkOutput("cntN", {26'b0, cntN}, DW'(mCnt[1]));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'd3, 5'd7, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h0,        32'h0,        1'b1, 6'd0};
        vecs[1]  = '{1'b1, 5'd5, 5'd6, 1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 1'b0, 32'h12345678, 32'h0,        1'b1, 6'd0};
        vecs[2]  = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 1'b0, 32'h12345678, 32'h0,        1'b0, 6'd1};
        vecs[3]  = '{1'b1, 5'd9, 5'd9, 1'b0, 5'd0, 32'h0,        1'b0, 5'd9, 1'b1, 32'h0,        32'h0,        1'b0, 6'd1};
        vecs[4]  = '{1'b1, 5'd9, 5'd5, 1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd9, 1'b1, 32'hA5A5A5A5, 32'h12345678, 1'b1, 6'd0};
        vecs[5]  = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 1'b0, 32'hA5A5A5A5, 32'h12345678, 1'b0, 6'd1};
        vecs[6]  = '{1'b0, 5'd0, 5'd0, 1'b1, 5'd4, 32'h55,       1'b1, 5'd4, 1'b1, 32'hA5A5A5A5, 32'h12345678, 1'b0, 6'd1};
        vecs[7]  = '{1'b1, 5'd4, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd4, 1'b1, 32'h55,       32'h0,        1'b0, 6'd1};
        vecs[8]  = '{1'b1, 5'd4, 5'd4, 1'b1, 5'd4, 32'h77,       1'b0, 5'd0, 1'b0, 32'h77,       32'h77,       1'b1, 6'd0};
        vecs[9]  = '{1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0, 32'h77,       32'h77,       1'b0, 6'd0};
        vecs[10] = '{1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h0,        32'h0,        1'b1, 6'd0};

        // Reset values
        reset = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
        modelReset();
        #3;
        checkOutput("resetRd1Z", rd1Z, 32'h0);
        checkOutput("resetRd2Z", rd2Z, 32'h0);
        checkOutput("resetValidZ", {31'b0, validZ}, 32'h0);
        checkOutput("resetCntZ", {26'b0, cntZ}, 32'h0);
        checkOutput("resetCntN", {26'b0, cntN}, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Reset arriving while a write to r3 is in flight discards the write
        @(negedge clock);
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, '0);
        #2 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        modelReset();

        // Directed vectors (expectations are for the ZeroReg=1 instance)
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].fetch, vecs[i].a1, vecs[i].a2, vecs[i].wb, vecs[i].wa,
                          vecs[i].wd, vecs[i].rs, vecs[i].rsa);
            #1;
            checkOutput($sformatf("vec%0d.conf", i), {31'b0, confZ}, {31'b0, vecs[i].expConf});
            applyCycle();
            checkOutput($sformatf("vec%0d.rd1", i), rd1Z, vecs[i].expRd1);
            checkOutput($sformatf("vec%0d.rd2", i), rd2Z, vecs[i].expRd2);
            checkOutput($sformatf("vec%0d.valid", i), {31'b0, validZ}, {31'b0, vecs[i].expValid});
            checkOutput($sformatf("vec%0d.cnt", i), {26'b0, cntZ}, {26'b0, vecs[i].expCnt});
        end

        // Register 0 is ordinary in the second instance
        checkOutput("plainR0Data", rd1N, 32'hFFFFFFFF);
        checkOutput("plainR0Valid", {31'b0, validN}, 32'h0);
        checkOutput("plainR0Cnt", {26'b0, cntN}, 32'h1);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 5'd0);
        #1;
        checkOutput("plainR0Conf", {31'b0, confN}, 32'h1);

        // Fill the scoreboard, then drain it
        for (int i = 1; i < DEPTH; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, AW'(i));
            applyCycle();
        end
        checkOutput("fullCntZ", {26'b0, cntZ}, 32'd31);
        checkOutput("fullCntN", {26'b0, cntN}, 32'd32);
        for (int i = 1; i < DEPTH; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, AW'(i), 32'h10000000 + i, 1'b0, '0);
            applyCycle();
        end
        checkOutput("drainCntZ", {26'b0, cntZ}, 32'd0);
        checkOutput("drainCntN", {26'b0, cntN}, 32'd1);
        applyStimulus(1'b1, 5'd31, 5'd30, 1'b0, '0, '0, 1'b0, '0);
        applyCycle();
        checkOutput("drainRd1", rd1Z, 32'h1000001F);
        checkOutput("drainRd2", rd2Z, 32'h1000001E);
        checkOutput("drainValid", {31'b0, validZ}, 32'h1);
        applyStimulus(1'b0, 5'd1, 5'd2, 1'b0, '0, '0, 1'b0, '0);
        applyCycle();
        checkOutput("holdRd1", rd1Z, 32'h1000001F);
        checkOutput("holdRd2", rd2Z, 32'h1000001E);
        checkOutput("holdValid", {31'b0, validZ}, 32'h0);

        // Asynchronous reset with live state and a reserve in flight
        applyStimulus(1'b1, 5'd3, 5'd4, 1'b0, '0, '0, 1'b1, 5'd6);
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncRd1", rd1Z, 32'h0);
        checkOutput("asyncCntN", {26'b0, cntN}, 32'h0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        modelReset();

        // Random traffic on a narrow address range to force collisions
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                          1'($urandom), AW'($urandom_range(0, 7)), $urandom,
                          1'($urandom), AW'($urandom_range(0, 7)));
            applyCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
